// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, width codes, FSM states, fault decode.
package lsu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned STRB_W = XLEN / 8;

    // RV32I load funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // RV32I store funct3 codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Access width, taken from funct3[1:0]
    localparam logic [1:0] WIDTH_B = 2'b00;
    localparam logic [1:0] WIDTH_H = 2'b01;
    localparam logic [1:0] WIDTH_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_FAULT  = 2'b10,
        ST_DONE   = 2'b11
    } lsu_state_e;

    typedef struct packed {
        logic illegal;
        logic misaligned;
    } fault_t;

    // Decode illegal/misaligned for a candidate access; illegal masks misaligned.
    function automatic fault_t check_fault(
        input logic       is_load,
        input logic       is_store,
        input logic [2:0] funct3,
        input logic [1:0] addr_lo
    );
        fault_t f;
        f = '0;
        if (is_load == is_store) begin
            f.illegal = 1'b1;
        end else if (is_load) begin
            f.illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end else begin
            f.illegal = funct3[2] || (funct3[1:0] == 2'b11);
        end
        if (!f.illegal) begin
            case (funct3[1:0])
                WIDTH_H: f.misaligned = addr_lo[0];
                WIDTH_W: f.misaligned = (addr_lo != 2'b00);
                default: f.misaligned = 1'b0;
            endcase
        end
        return f;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store replication/strobes and load extraction/extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]        st_funct3,
    input  logic [1:0]        st_addr_lo,
    input  logic [XLEN-1:0]   store_data,
    input  logic [2:0]        ld_funct3,
    input  logic [1:0]        ld_addr_lo,
    input  logic [XLEN-1:0]   rdata,
    output logic [XLEN-1:0]   wdata_c,
    output logic [STRB_W-1:0] wstrb_c,
    output logic [XLEN-1:0]   ld_data_c
);

    logic [XLEN-1:0] shifted;

    // Replicate the store value across lanes and select the target byte strobes.
    always_comb begin
        wdata_c = store_data;
        wstrb_c = 4'b1111;
        case (st_funct3[1:0])
            WIDTH_B: begin
                wdata_c = {4{store_data[7:0]}};
                wstrb_c = 4'b0001 << st_addr_lo;
            end
            WIDTH_H: begin
                wdata_c = {2{store_data[15:0]}};
                wstrb_c = 4'b0011 << st_addr_lo;
            end
            default: ;
        endcase
    end

    // Move the addressed lane to bit 0, then sign- or zero-extend by funct3.
    always_comb begin
        shifted   = rdata >> {ld_addr_lo, 3'b000};
        ld_data_c = rdata;
        case (ld_funct3)
            F3_LB:   ld_data_c = {{24{shifted[7]}}, shifted[7:0]};
            F3_LBU:  ld_data_c = {24'b0, shifted[7:0]};
            F3_LH:   ld_data_c = {{16{shifted[15]}}, shifted[15:0]};
            F3_LHU:  ld_data_c = {16'b0, shifted[15:0]};
            default: ld_data_c = rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: one outstanding access on a req/ready data port with optional timeout.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_load,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   store_data,
    output logic              busy,
    output logic              done,
    output logic [XLEN-1:0]   load_data,
    output logic              misaligned,
    output logic              illegal,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    input  logic              mem_ready,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int unsigned CNT_W = 32;

    lsu_state_e        state;
    logic [2:0]        funct3_q;
    logic [1:0]        addr_lo_q;
    logic              is_load_q;
    logic [CNT_W-1:0]  wait_cnt;

    fault_t            fault_c;
    logic              timeout_c;
    logic [XLEN-1:0]   wdata_c;
    logic [STRB_W-1:0] wstrb_c;
    logic [XLEN-1:0]   ld_data_c;

    assign fault_c   = check_fault(is_load, is_store, funct3, addr[1:0]);
    assign timeout_c = (TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Store lanes come from the live inputs at accept; load extraction uses the latched access.
    lsu_align u_align (
        .st_funct3  (funct3),
        .st_addr_lo (addr[1:0]),
        .store_data (store_data),
        .ld_funct3  (funct3_q),
        .ld_addr_lo (addr_lo_q),
        .rdata      (mem_rdata),
        .wdata_c    (wdata_c),
        .wstrb_c    (wstrb_c),
        .ld_data_c  (ld_data_c)
    );

    // Access FSM with registered memory port, status flags and load result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            funct3_q   <= '0;
            addr_lo_q  <= '0;
            is_load_q  <= 1'b0;
            wait_cnt   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_data  <= '0;
            misaligned <= 1'b0;
            illegal    <= 1'b0;
            bus_err    <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        funct3_q   <= funct3;
                        addr_lo_q  <= addr[1:0];
                        is_load_q  <= is_load;
                        wait_cnt   <= '0;
                        busy       <= 1'b1;
                        load_data  <= '0;
                        bus_err    <= 1'b0;
                        misaligned <= fault_c.misaligned;
                        illegal    <= fault_c.illegal;
                        mem_addr   <= {addr[31:2], 2'b00};
                        if (fault_c.illegal || fault_c.misaligned) begin
                            // Fault completes without touching memory
                            done      <= 1'b1;
                            mem_we    <= 1'b0;
                            mem_wdata <= '0;
                            mem_wstrb <= '0;
                            state     <= ST_FAULT;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_wdata <= is_store ? wdata_c : '0;
                            mem_wstrb <= is_store ? wstrb_c : '0;
                            state     <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (mem_ready) begin
                        load_data <= is_load_q ? ld_data_c : '0;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        done      <= 1'b1;
                        state     <= ST_DONE;
                    end else if (timeout_c) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        bus_err   <= 1'b1;
                        done      <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        wait_cnt  <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_FAULT: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    mem_req <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit that sits directly downstream of the integer ALU in the execute stage.
- Takes the ALU-computed effective address (rs1 + imm) and the rs2 store value for RV32I LB/LH/LW/LBU/LHU/SB/SH/SW.
- Drives a simple req/ready data-memory port and returns sign- or zero-extended load data to writeback.
- Multi-cycle, one access outstanding; the core stalls while busy is high.

Parameters:
- TIMEOUT_CYCLES, 0, max cycles mem_req may wait for mem_ready; 0 = no timeout.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin access; sampled only in IDLE
- is_load  input  1  access is a load
- is_store  input  1  access is a store
- funct3  input  3  RV32I load/store width/sign field
- addr  input  32  effective address from ALU result
- store_data  input  32  rs2 value
- busy  output  1  high from the cycle after an accepted start until the cycle after done
- done  output  1  one-cycle completion pulse
- load_data  output  32  extended load result; valid when done is high, held until next accepted start
- misaligned  output  1  fault flag, valid with done
- illegal  output  1  fault flag, valid with done
- bus_err  output  1  timeout fault flag, valid with done
- mem_req  output  1  memory request
- mem_we  output  1  write enable
- mem_addr  output  32  word address, {addr[31:2],2'b00}
- mem_wdata  output  32  lane-replicated store data
- mem_wstrb  output  4  byte strobes; 0 for loads
- mem_ready  input  1  memory accepts/completes the request this cycle
- mem_rdata  input  32  read word; valid with mem_ready

Behaviour:
- Reset: state IDLE. Outputs busy, done, misaligned, illegal, bus_err, mem_req and mem_we are 0. Outputs load_data, mem_addr, mem_wdata, mem_wstrb are 32'b0/4'b0.
- States and transitions:
  - IDLE
    - start=1 and fault → FAULT.
    - start=1 and no fault → ACCESS.
    - All inputs are latched on the accepted start.
  - ACCESS
    - mem_req=1; mem_addr, mem_we, mem_wdata and mem_wstrb are held stable.
    - mem_ready=1 → DONE; mem_rdata is captured on this edge.
    - TIMEOUT_CYCLES>0 and wait counter reaches TIMEOUT_CYCLES with no mem_ready → DONE with bus_err=1.
  - FAULT
    - done=1 with misaligned or illegal set.
    - No memory access occurs; load_data = 0.
    - Next state IDLE.
  - DONE
    - done=1; flags reflect the access; mem_req=0.
    - Next state IDLE.
- Latency:
  - start is accepted at edge N. mem_req is high from cycle N+1.
  - With mem_ready in the first ACCESS cycle, done is high at cycle N+2.
  - Each wait cycle adds one cycle.
  - A faulting access has done at N+1.
- Fault rules:
  - illegal:
    - is_load and is_store both 0, or both 1.
    - Load funct3 ∈ {011,110,111}.
    - Store funct3 ∉ {000,001,010}.
  - misaligned:
    - Halfword access with addr[0]=1.
    - Word access with addr[1:0]≠0.
  - illegal takes priority; misaligned=0 when illegal=1.
- Store lanes:
  - SB: wdata={4{sd[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - SH: wdata={2{sd[15:0]}}, wstrb=4'b0011<<addr[1:0].
  - SW: wdata=sd, wstrb=4'b1111.
- Load extract: byte lane = rdata >> (addr[1:0]*8).
  - LB / LBU: sign- / zero-extend bits [7:0] of the shifted word.
  - LH / LHU: sign- / zero-extend bits [15:0] of the shifted word.
  - LW: rdata unchanged.
- Stores leave load_data = 0.
- start while not IDLE is ignored; the in-flight access is not disturbed.
- mem_ready outside ACCESS is ignored.
- Wait counter clears on every entry to ACCESS.
- rst in any state: next cycle is IDLE with all outputs at reset values. A memory response arriving afterwards is ignored.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 constants LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010.
  - Width-code constants.
  - The 2-bit state encoding IDLE/ACCESS/FAULT/DONE.
- Sub-module lsu_align (combinational) holds store lane replication/strobe generation and load extraction/extension. lsu holds the FSM, latches, timeout counter and memory port.

Test Plan:
1. LW addr 0x100, mem_ready after 2 wait cycles, rdata 0xDEADBEEF → mem_addr 0x100, mem_we 0, mem_wstrb 0, req high 3 cycles, done one cycle later, load_data 0xDEADBEEF.
2. Loads with rdata 0x80123456:
   - LB addr 0x103 → 0xFFFFFF80.
   - LBU addr 0x103 → 0x00000080.
   - LHU addr 0x102 → 0x00008012.
   - LH addr 0x102 → 0xFFFF8012.
3. Stores:
   - SB addr 0x201, store_data 0x12345678 → mem_addr 0x200, wdata 0x78787878, wstrb 0010, we 1.
   - SH addr 0x202 → wdata 0x56785678, wstrb 1100.
4. Faults, neither issues mem_req:
   - LW addr 0x102 → done at N+1, misaligned=1, load_data 0.
   - Load funct3=011 → done at N+1, illegal=1, misaligned=0.
5. TIMEOUT_CYCLES=4, mem_ready held 0 → mem_req high exactly 4 cycles, then done with bus_err=1, busy falls the cycle after done.
6. rst pulsed during ACCESS → next cycle mem_req 0, busy 0, done 0. A second start asserted while busy (without reset) is ignored: exactly one done observed.
